mig_arbiter: RTL and testbench

MIG_ARBITER -- requirements
Module: mig_arbiter

---
 rtl/mig_arb_pkg.sv | 22 ++
 rtl/mig_arb_tag_fifo.sv | 57 +++++
 rtl/mig_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_mig_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mig_arb_pkg.sv
// Shared definitions for the two-port MIG arbiter: MIG command codes,
// data/mask widths and the arbiter FSM state encoding.
package mig_arb_pkg;

  localparam int DATA_W = 256;
  localparam int MASK_W = 32;

  localparam logic [2:0] DRAM_READ  = 3'b001;
  localparam logic [2:0] DRAM_WRITE = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WDF  = 2'd1,
    S_CMD  = 2'd2
  } arb_state_t;

  // Anything that is not a read takes the write-data path.
  function automatic logic is_read(input logic [2:0] cmd);
    return cmd == DRAM_READ;
  endfunction

endpackage

// File: rtl/mig_arb_tag_fifo.sv
// Tag FIFO: remembers which port issued each outstanding read so returned
// data can be routed back in order. One bit per entry, DEPTH entries.
// Pops while empty and pushes while full (without a pop) are ignored.
module mig_arb_tag_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     push_id,
  input  logic                     pop,
  output logic                     pop_id,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_id  = mem[rd_ptr];

  // Storage, power-of-two wrapping pointers and occupancy count.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_id;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mig_arbiter.sv
// Two-port arbiter in front of a MIG user interface. Grants one request at
// a time, drives the write-data and command channels, and routes returned
// read data back to the issuing port through an in-order tag FIFO.
// Define MIG_ARB_FIXED_PRIO_EN to make port 0 win every tie; otherwise ties
// are resolved round-robin.
module mig_arbiter
  import mig_arb_pkg::*;
#(
  parameter int TAG_DEPTH = 16,
  parameter int ADDR_W    = 30
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              calib_done,

  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic [2:0]        p0_req_cmd,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [DATA_W-1:0] p0_req_wdata,
  input  logic [MASK_W-1:0] p0_req_mask,
  output logic              p0_rd_valid,
  output logic [DATA_W-1:0] p0_rd_data,

  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic [2:0]        p1_req_cmd,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [DATA_W-1:0] p1_req_wdata,
  input  logic [MASK_W-1:0] p1_req_mask,
  output logic              p1_rd_valid,
  output logic [DATA_W-1:0] p1_rd_data,

  input  logic              app_rdy,
  input  logic              app_wdf_rdy,
  input  logic              app_rd_data_valid,
  input  logic [DATA_W-1:0] app_rd_data,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  output logic              app_wdf_wren,
  output logic [DATA_W-1:0] app_wdf_data,
  output logic              app_wdf_end,
  output logic [MASK_W-1:0] app_wdf_mask,

  output logic              tag_err
);

  localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

  arb_state_t        state;
  arb_state_t        state_nxt;

  logic [2:0]        lat_cmd;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [MASK_W-1:0] lat_mask;
  logic              lat_id;

  logic              elig0;
  logic              elig1;
  logic              grant;
  logic              grant_id;

  logic [2:0]        sel_cmd;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [MASK_W-1:0] sel_mask;

  logic              tag_push;
  logic              tag_pop;
  logic              tag_pop_id;
  logic              tag_full;
  logic              tag_empty;
  logic [CNT_W-1:0]  tag_count;

  // A read needs a free tag slot; a write can always go.
  assign elig0 = p0_req_valid && (!is_read(p0_req_cmd) || !tag_full);
  assign elig1 = p1_req_valid && (!is_read(p1_req_cmd) || !tag_full);

`ifdef MIG_ARB_FIXED_PRIO_EN
  // Fixed priority: no history is kept, port 0 always wins a tie.
`else
  logic rr_last;

  // Remember the most recent winner; reset value makes port 0 win first.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      rr_last <= 1'b1;
    end else if (grant) begin
      rr_last <= grant_id;
    end
  end
`endif

  // Pick a winner only while idle and calibrated; reset masks the grant.
  always_comb begin
    grant    = 1'b0;
    grant_id = 1'b0;
    if (state == S_IDLE && calib_done && !rst) begin
      if (elig0 && elig1) begin
        grant = 1'b1;
`ifdef MIG_ARB_FIXED_PRIO_EN
        grant_id = 1'b0;
`else
        grant_id = ~rr_last;
`endif
      end else if (elig0 || elig1) begin
        grant    = 1'b1;
        grant_id = elig1;
      end
    end
  end

  assign p0_req_ready = grant && !grant_id;
  assign p1_req_ready = grant && grant_id;

  assign sel_cmd   = grant_id ? p1_req_cmd   : p0_req_cmd;
  assign sel_addr  = grant_id ? p1_req_addr  : p0_req_addr;
  assign sel_wdata = grant_id ? p1_req_wdata : p0_req_wdata;
  assign sel_mask  = grant_id ? p1_req_mask  : p0_req_mask;

  // State register.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and MIG channel strobes; writes present data before command.
  always_comb begin
    state_nxt    = state;
    app_en       = 1'b0;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant) begin
          state_nxt = is_read(sel_cmd) ? S_CMD : S_WDF;
        end
      end
      S_WDF: begin
        app_wdf_wren = 1'b1;
        app_wdf_end  = 1'b1;
        if (app_wdf_rdy) begin
          state_nxt = S_CMD;
        end
      end
      S_CMD: begin
        app_en = 1'b1;
        if (app_rdy) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Capture the winning request so the MIG sees stable values.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      lat_cmd   <= DRAM_WRITE;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_mask  <= '0;
      lat_id    <= 1'b0;
    end else if (grant) begin
      lat_cmd   <= sel_cmd;
      lat_addr  <= sel_addr;
      lat_wdata <= sel_wdata;
      lat_mask  <= sel_mask;
      lat_id    <= grant_id;
    end
  end

  assign app_cmd      = lat_cmd;
  assign app_addr     = lat_addr;
  assign app_wdf_data = lat_wdata;
  assign app_wdf_mask = lat_mask;

  assign tag_push = (state == S_CMD) && app_rdy && is_read(lat_cmd);
  assign tag_pop  = app_rd_data_valid;

  mig_arb_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .sys_clk (sys_clk),
    .rst     (rst),
    .push    (tag_push),
    .push_id (lat_id),
    .pop     (tag_pop),
    .pop_id  (tag_pop_id),
    .full    (tag_full),
    .empty   (tag_empty),
    .count   (tag_count)
  );

  // Route returned data to the port at the FIFO head; data with no tag is
  // dropped and flagged until the next reset.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      p0_rd_valid <= 1'b0;
      p1_rd_valid <= 1'b0;
      p0_rd_data  <= '0;
      p1_rd_data  <= '0;
      tag_err     <= 1'b0;
    end else begin
      p0_rd_valid <= 1'b0;
      p1_rd_valid <= 1'b0;
      if (app_rd_data_valid) begin
        if (tag_empty) begin
          tag_err <= 1'b1;
        end else if (tag_pop_id) begin
          p1_rd_valid <= 1'b1;
          p1_rd_data  <= app_rd_data;
        end else begin
          p0_rd_valid <= 1'b1;
          p0_rd_data  <= app_rd_data;
        end
      end
    end
  end

  a_one_hot_ready: assert property (@(posedge sys_clk) disable iff (rst)
    !(p0_req_ready && p1_req_ready));

  a_tag_flags: assert property (@(posedge sys_clk) disable iff (rst)
    tag_empty == (tag_count == '0));

endmodule

// File: tb/tb_mig_arbiter.sv
// Directed, table-driven bench for mig_arbiter (TAG_DEPTH = 4). Expectations
// follow MIG_ARB_FIXED_PRIO_EN when the bench is built with it defined.
module tb_mig_arbiter;
  import mig_arb_pkg::*;

  localparam int ADDR_W = 30;

  logic              sys_clk;
  logic              rst;
  logic              calib_done;
  logic              p0_req_valid, p1_req_valid;
  logic              p0_req_ready, p1_req_ready;
  logic [2:0]        p0_req_cmd, p1_req_cmd;
  logic [ADDR_W-1:0] p0_req_addr, p1_req_addr;
  logic [255:0]      p0_req_wdata, p1_req_wdata;
  logic [31:0]       p0_req_mask, p1_req_mask;
  logic              p0_rd_valid, p1_rd_valid;
  logic [255:0]      p0_rd_data, p1_rd_data;
  logic              app_rdy, app_wdf_rdy, app_rd_data_valid;
  logic [255:0]      app_rd_data;
  logic              app_en;
  logic [2:0]        app_cmd;
  logic [ADDR_W-1:0] app_addr;
  logic              app_wdf_wren, app_wdf_end;
  logic [255:0]      app_wdf_data;
  logic [31:0]       app_wdf_mask;
  logic              tag_err;

  int n_compared;
  int n_mismatched;

  typedef struct {
    logic       calib;
    logic       v0;
    logic [2:0] c0;
    logic       v1;
    logic [2:0] c1;
    int         exp_grant;
    logic       tie;
  } vec_t;

  vec_t vecs[9];

  mig_arbiter #(.TAG_DEPTH(4), .ADDR_W(ADDR_W)) dut (
    .sys_clk(sys_clk), .rst(rst), .calib_done(calib_done),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_cmd(p0_req_cmd),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_req_mask(p0_req_mask),
    .p0_rd_valid(p0_rd_valid), .p0_rd_data(p0_rd_data),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_cmd(p1_req_cmd),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_req_mask(p1_req_mask),
    .p1_rd_valid(p1_rd_valid), .p1_rd_data(p1_rd_data),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data(app_rd_data), .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
    .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data), .app_wdf_end(app_wdf_end),
    .app_wdf_mask(app_wdf_mask), .tag_err(tag_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [255:0] word8(input logic [31:0] w);
    return {8{w}};
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic resetDut();
    @(negedge sys_clk);
    rst = 1'b1;
    app_rd_data_valid = 1'b0;
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
    repeat (2) @(negedge sys_clk);
    rst = 1'b0;
  endtask

  // One vector = one complete transaction, including read-data return.
  task automatic applyStimulus(input vec_t v, input int idx);
    int           g;
    logic [2:0]   gcmd;
    logic [29:0]  gaddr;
    logic [255:0] gdata;
    logic [31:0]  gmask;
    logic [255:0] rdata;
    g = v.exp_grant;
`ifdef MIG_ARB_FIXED_PRIO_EN
    if (v.tie) g = 0;
`endif
    @(negedge sys_clk);
    calib_done   = v.calib;
    p0_req_valid = v.v0;
    p0_req_cmd   = v.c0;
    p0_req_addr  = 30'h1000 + 30'(idx);
    p0_req_wdata = word8(32'hA000_0000 | 32'(idx));
    p0_req_mask  = 32'h0000_000F;
    p1_req_valid = v.v1;
    p1_req_cmd   = v.c1;
    p1_req_addr  = 30'h2000 + 30'(idx);
    p1_req_wdata = word8(32'hB000_0000 | 32'(idx));
    p1_req_mask  = 32'hF000_0000;
    app_rdy      = 1'b1;
    app_wdf_rdy  = 1'b1;
    #1;
    checkOutput("grant_p0", p0_req_ready, g == 0);
    checkOutput("grant_p1", p1_req_ready, g == 1);
    gcmd  = (g == 1) ? p1_req_cmd   : p0_req_cmd;
    gaddr = (g == 1) ? p1_req_addr  : p0_req_addr;
    gdata = (g == 1) ? p1_req_wdata : p0_req_wdata;
    gmask = (g == 1) ? p1_req_mask  : p0_req_mask;
    @(negedge sys_clk);
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
    calib_done   = 1'b1;
    if (g < 0) begin
      checkOutput("idle_app_en", app_en, 1'b0);
      checkOutput("idle_wren", app_wdf_wren, 1'b0);
    end else if (gcmd == DRAM_READ) begin
      checkOutput("rd_app_en", app_en, 1'b1);
      checkOutput("rd_app_cmd", app_cmd, DRAM_READ);
      checkOutput("rd_app_addr", app_addr, gaddr);
      @(negedge sys_clk);
      rdata = word8(32'h5EED_0000 | 32'(idx));
      app_rd_data_valid = 1'b1;
      app_rd_data = rdata;
      @(negedge sys_clk);
      app_rd_data_valid = 1'b0;
      checkOutput("rd_valid_p0", p0_rd_valid, g == 0);
      checkOutput("rd_valid_p1", p1_rd_valid, g == 1);
      checkOutput("rd_data", (g == 1) ? p1_rd_data : p0_rd_data, rdata);
    end else begin
      checkOutput("wr_wren", app_wdf_wren, 1'b1);
      checkOutput("wr_en_low", app_en, 1'b0);
      checkOutput("wr_data", app_wdf_data, gdata);
      checkOutput("wr_mask", app_wdf_mask, gmask);
      @(negedge sys_clk);
      checkOutput("wr_app_en", app_en, 1'b1);
      checkOutput("wr_app_cmd", app_cmd, DRAM_WRITE);
      checkOutput("wr_app_addr", app_addr, gaddr);
      @(negedge sys_clk);
      checkOutput("wr_done", app_en, 1'b0);
    end
  endtask

  initial begin
    int           ngrant;
    int           last;
    int           grants[4];
    int           exp_port;
    int           wren_cnt, en_cnt, accepts, bad, cnt, leaked;
    logic [255:0] rdata;

    n_compared   = 0;
    n_mismatched = 0;
    rst = 1'b1;
    calib_done = 1'b1;
    p0_req_valid = 1'b1; p0_req_cmd = DRAM_WRITE; p0_req_addr = '0;
    p0_req_wdata = '0; p0_req_mask = '0;
    p1_req_valid = 1'b1; p1_req_cmd = DRAM_READ; p1_req_addr = '0;
    p1_req_wdata = '0; p1_req_mask = '0;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data_valid = 1'b0; app_rd_data = '0;

    // Reset state, with requests pending to prove grants are held off.
    repeat (2) @(negedge sys_clk);
    #1;
    checkOutput("rst_ready0", p0_req_ready, 1'b0);
    checkOutput("rst_ready1", p1_req_ready, 1'b0);
    checkOutput("rst_app_en", app_en, 1'b0);
    checkOutput("rst_wren", {app_wdf_wren, app_wdf_end}, 2'b00);
    checkOutput("rst_app_addr", app_addr, '0);
    checkOutput("rst_app_cmd", app_cmd, '0);
    checkOutput("rst_rd_valid", {p0_rd_valid, p1_rd_valid}, 2'b00);
    checkOutput("rst_rd_data", p0_rd_data | p1_rd_data, '0);
    checkOutput("rst_tag_err", tag_err, 1'b0);
    resetDut();

    // Continuous reads from both ports; then in-order data return.
    p0_req_valid = 1'b1; p0_req_cmd = DRAM_READ; p0_req_addr = 30'h00;
    p1_req_valid = 1'b1; p1_req_cmd = DRAM_READ; p1_req_addr = 30'h08;
    ngrant = 0;
    last = 0;
    for (int i = 0; i < 20 && ngrant < 4; i++) begin
      #1;
      if (app_en) checkOutput("rr_app_addr", app_addr, (last == 1) ? 30'h08 : 30'h00);
      if (p0_req_ready && p1_req_ready) checkOutput("rr_one_hot", 2'b11, 2'b01);
      if (p0_req_ready) begin grants[ngrant] = 0; last = 0; ngrant++; end
      else if (p1_req_ready) begin grants[ngrant] = 1; last = 1; ngrant++; end
      @(negedge sys_clk);
    end
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
    checkOutput("rr_grant_count", ngrant, 4);
    for (int k = 0; k < ngrant; k++) begin
`ifdef MIG_ARB_FIXED_PRIO_EN
      exp_port = 0;
`else
      exp_port = k % 2;
`endif
      checkOutput("rr_grant_order", grants[k], exp_port);
    end
    @(negedge sys_clk);
    for (int k = 0; k < 4; k++) begin
`ifdef MIG_ARB_FIXED_PRIO_EN
      exp_port = 0;
`else
      exp_port = k % 2;
`endif
      rdata = word8(32'hD000_0000 | 32'(k));
      app_rd_data_valid = 1'b1;
      app_rd_data = rdata;
      @(negedge sys_clk);
      checkOutput("ret_valid_p0", p0_rd_valid, exp_port == 0);
      checkOutput("ret_valid_p1", p1_rd_valid, exp_port == 1);
      checkOutput("ret_data", (exp_port == 1) ? p1_rd_data : p0_rd_data, rdata);
    end
    app_rd_data_valid = 1'b0;
    @(negedge sys_clk);
    checkOutput("ret_pulse_end", {p0_rd_valid, p1_rd_valid}, 2'b00);
    checkOutput("ret_no_err", tag_err, 1'b0);

    // Table of single transactions from a fresh round-robin state.
    resetDut();
    vecs[0] = '{1'b0, 1'b1, DRAM_WRITE, 1'b1, DRAM_WRITE, -1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, DRAM_WRITE, 1'b1, DRAM_WRITE,  0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, DRAM_READ,  1'b1, DRAM_READ,   1, 1'b1};
    vecs[3] = '{1'b1, 1'b0, DRAM_READ,  1'b1, DRAM_WRITE,  1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, DRAM_READ,  1'b1, DRAM_READ,   0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, DRAM_READ,  1'b0, DRAM_READ,   0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, DRAM_WRITE, 1'b1, DRAM_WRITE,  1, 1'b1};
    vecs[7] = '{1'b1, 1'b1, DRAM_READ,  1'b1, DRAM_WRITE,  0, 1'b1};
    vecs[8] = '{1'b1, 1'b0, DRAM_READ,  1'b0, DRAM_WRITE, -1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Write with slow write-data and command acceptance.
    @(negedge sys_clk);
    p0_req_valid = 1'b1; p0_req_cmd = DRAM_WRITE; p0_req_addr = 30'h40;
    p0_req_wdata = word8(32'hA5A5_A5A5); p0_req_mask = 32'h0;
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    #1;
    checkOutput("w_grant", p0_req_ready, 1'b1);
    wren_cnt = 0; en_cnt = 0; accepts = 0; bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge sys_clk);
      p0_req_valid = 1'b0;
      if (app_wdf_wren) begin
        wren_cnt++;
        if (app_wdf_data !== word8(32'hA5A5_A5A5) || app_wdf_mask !== 32'h0 ||
            !app_wdf_end || app_en) bad++;
      end
      if (app_en) begin
        en_cnt++;
        if (app_addr !== 30'h40 || app_cmd !== DRAM_WRITE) bad++;
      end
      if (!app_wdf_wren && app_wdf_end) bad++;
      app_wdf_rdy = app_wdf_wren && (wren_cnt == 4);
      app_rdy = app_en && (en_cnt == 3);
      if (app_en && app_rdy) accepts++;
    end
    checkOutput("w_wren_cycles", wren_cnt, 4);
    checkOutput("w_en_cycles", en_cnt, 3);
    checkOutput("w_accepts", accepts, 1);
    checkOutput("w_stable", bad, 0);
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;

    // Full tag FIFO blocks reads but not writes; one return unblocks.
    resetDut();
    p0_req_valid = 1'b1; p0_req_cmd = DRAM_READ; p0_req_addr = 30'h10;
    cnt = 0;
    for (int i = 0; i < 20 && cnt < 4; i++) begin
      #1;
      if (p0_req_ready) cnt++;
      @(negedge sys_clk);
    end
    checkOutput("full_fill", cnt, 4);
    p1_req_valid = 1'b1; p1_req_cmd = DRAM_WRITE; p1_req_addr = 30'h20;
    @(negedge sys_clk);
    #1;
    checkOutput("full_rd_block", p0_req_ready, 1'b0);
    checkOutput("full_wr_grant", p1_req_ready, 1'b1);
    @(negedge sys_clk);
    p1_req_valid = 1'b0;
    leaked = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      #1;
      if (p0_req_ready) leaked++;
    end
    checkOutput("full_hold", leaked, 0);
    app_rd_data_valid = 1'b1;
    app_rd_data = word8(32'h1234_5678);
    @(negedge sys_clk);
    app_rd_data_valid = 1'b0;
    #1;
    checkOutput("full_unblock", p0_req_ready, 1'b1);
    checkOutput("full_ret_p0", p0_rd_valid, 1'b1);
    @(negedge sys_clk);
    p0_req_valid = 1'b0;

    // Return with no tag outstanding, then reset in the command phase.
    resetDut();
    app_rd_data_valid = 1'b1;
    app_rd_data = word8(32'hDEAD_BEEF);
    @(negedge sys_clk);
    app_rd_data_valid = 1'b0;
    checkOutput("err_set", tag_err, 1'b1);
    checkOutput("err_no_valid", {p0_rd_valid, p1_rd_valid}, 2'b00);
    @(negedge sys_clk);
    checkOutput("err_sticky", tag_err, 1'b1);
    p0_req_valid = 1'b1; p0_req_cmd = DRAM_WRITE; p0_req_addr = 30'h80;
    app_rdy = 1'b0; app_wdf_rdy = 1'b1;
    @(negedge sys_clk);
    p0_req_valid = 1'b0;
    @(negedge sys_clk);
    checkOutput("cmd_app_en", app_en, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_app_en", app_en, 1'b0);
    checkOutput("arst_tag_err", tag_err, 1'b0);
    @(negedge sys_clk);
    rst = 1'b0;
    app_rdy = 1'b1;
    @(negedge sys_clk);
    checkOutput("arst_after_en", app_en, 1'b0);
    checkOutput("arst_after_rd", {p0_rd_valid, p1_rd_valid}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
